mdu_ctrl: RTL

mdu_ctrl is the issue controller that sits between the E stage and the multiply/divide unit (MDU). It buffers multiply/divide and HI/LO commands in a small in-order queue and issues at most one command per cycle to the MDU. It never issues while the MDU is busy and returns MFHI/MFLO read data with a valid pulse. It also drives the D-stage stall signal (pending) and supports flushing of queued, not-yet-issued commands on an exception.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_ctrl_if.sv | 38 +++
 rtl/mdu_cmd_fifo.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the MDU issue controller: command encoding, MDU op codes,
// controller FSM states and the queued request record.
package mdu_pkg;

   // E-stage command encoding; bit 2 clear marks the long (mult/div) group
   typedef enum logic [2:0] {
      CMD_MULT  = 3'd0,
      CMD_MULTU = 3'd1,
      CMD_DIV   = 3'd2,
      CMD_DIVU  = 3'd3,
      CMD_MTHI  = 3'd4,
      CMD_MTLO  = 3'd5,
      CMD_MFHI  = 3'd6,
      CMD_MFLO  = 3'd7
   } cmd_e;

   // Op codes understood by the MDU on mdu_start
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;

   // IDLE issues from the queue, WAIT blocks until the MDU drops busy
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // One queue entry: command plus both operands (67 bits)
   typedef struct packed {
      cmd_e        cmd;
      logic [31:0] a;
      logic [31:0] b;
   } mdu_req_t;

   localparam int REQ_W = $bits(mdu_req_t);

   // Long operations occupy the MDU for several cycles
   function automatic logic is_long_op(cmd_e c);
      return (c == CMD_MULT) || (c == CMD_MULTU) || (c == CMD_DIV) || (c == CMD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bus bundle between the E stage, the issue controller and the MDU.
// slave: the controller's view; master: the surrounding pipeline/MDU view.
interface mdu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_cmd;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        mdu_start;
   logic [2:0]  mdu_op;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        mdu_hi_write;
   logic        mdu_lo_write;
   logic        mdu_busy;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        pending;

   modport slave (
      input  req_valid, req_cmd, req_a, req_b, flush,
      input  mdu_busy, mdu_hi, mdu_lo,
      output req_ready,
      output mdu_start, mdu_op, mdu_a, mdu_b, mdu_hi_write, mdu_lo_write,
      output rd_valid, rd_data, pending
   );

   modport master (
      output req_valid, req_cmd, req_a, req_b, flush,
      output mdu_busy, mdu_hi, mdu_lo,
      input  req_ready,
      input  mdu_start, mdu_op, mdu_a, mdu_b, mdu_hi_write, mdu_lo_write,
      input  rd_valid, rd_data, pending
   );
endinterface

// File: rtl/mdu_cmd_fifo.sv
// In-order command queue. DEPTH must be a power of two so the pointers wrap
// for free; the occupancy counter spans 0..DEPTH inclusive.
module mdu_cmd_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 67,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           cnt;
   logic                    do_push;
   logic                    do_pop;

   // Guard locally so a stray push when full or a pop when empty is harmless;
   // flush overrides both.
   assign do_push = push && !full  && !flush;
   assign do_pop  = pop  && !empty && !flush;

   // Pointer and occupancy bookkeeping; flush empties the queue on the edge
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage; data needs no reset since occupancy gates its use
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/mdu_ctrl.sv
// Issue controller between the E stage and the multiply/divide unit.
// Commands are queued in order and issued one per cycle from IDLE; a long
// op parks the FSM in WAIT until the MDU reports not-busy, so any HI/LO
// access behind it sees the updated registers. MDU drive is combinational
// from the queue head; MFHI/MFLO data is registered and pulsed on rd_valid.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave bus
);

   localparam int CW = $clog2(DEPTH + 1);

   state_e        state;
   mdu_req_t      in_req;
   mdu_req_t      head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          req_ready;
   logic          push;
   logic          pop;
   logic          rd_valid_q;
   logic [31:0]   rd_data_q;

   logic          start;
   logic [2:0]    op;
   logic [31:0]   op_a;
   logic [31:0]   op_b;
   logic          hi_wr;
   logic          lo_wr;

   assign in_req    = '{cmd: cmd_e'(bus.req_cmd), a: bus.req_a, b: bus.req_b};
   assign req_ready = !full && !bus.flush;
   assign push      = bus.req_valid && req_ready;
   // The head only leaves the queue from IDLE, and never in a flush cycle
   assign pop       = (state == ST_IDLE) && !empty && !bus.flush;

   mdu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (REQ_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.flush),
      .din   (in_req),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Issue decode: exactly one strobe for the popped command, zeros otherwise
   always_comb begin
      start = 1'b0;
      op    = MDU_MULT;
      op_a  = '0;
      op_b  = '0;
      hi_wr = 1'b0;
      lo_wr = 1'b0;
      if (pop) begin
         case (head.cmd)
            CMD_MULT:  begin start = 1'b1; op = MDU_MULT;  op_a = head.a; op_b = head.b; end
            CMD_MULTU: begin start = 1'b1; op = MDU_MULTU; op_a = head.a; op_b = head.b; end
            CMD_DIV:   begin start = 1'b1; op = MDU_DIV;   op_a = head.a; op_b = head.b; end
            CMD_DIVU:  begin start = 1'b1; op = MDU_DIVU;  op_a = head.a; op_b = head.b; end
            CMD_MTHI:  begin hi_wr = 1'b1; op_a = head.a; end
            CMD_MTLO:  begin lo_wr = 1'b1; op_a = head.a; end
            default:   ; // MFHI/MFLO only touch the read-data register
         endcase
      end
   end

   // Issue FSM plus the registered read-data return path
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  if (is_long_op(head.cmd)) begin
                     state <= ST_WAIT;
                  end else if (head.cmd == CMD_MFHI) begin
                     rd_data_q  <= bus.mdu_hi;
                     rd_valid_q <= 1'b1;
                  end else if (head.cmd == CMD_MFLO) begin
                     rd_data_q  <= bus.mdu_lo;
                     rd_valid_q <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               // The exit cycle itself never issues; IDLE picks up next cycle
               if (!bus.mdu_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.mdu_start    = start;
   assign bus.mdu_op       = op;
   assign bus.mdu_a        = op_a;
   assign bus.mdu_b        = op_b;
   assign bus.mdu_hi_write = hi_wr;
   assign bus.mdu_lo_write = lo_wr;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   // D-stage stall: anything queued or a long op still running
   assign bus.pending      = (state == ST_WAIT) || (count != '0);

endmodule
